// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// State enum, instruction field codes and datapath select encodings.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC_R, S_ALUWB, S_ADDI_EX, S_IMMWB,
        S_BRANCH, S_JUMP, S_JAL, S_JR, S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD, CLS_SUB, CLS_SLT, CLS_FUNCT
    } alu_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU operation decoder: state class plus funct to alu_op.
// Flags unsupported funct codes when the class defers to funct.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);

    // Select the ALU operation; unknown R-type funct is flagged
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (cls)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_SLT: alu_op = ALU_SLT;
            default: begin
                case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with memory wait watchdog.
// Optional MIPS_MC_PERF_EN adds instr_count / stall_count.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       fault
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] stall_count
`endif
);

    localparam int WW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] WLAST = WW'(WAIT_LIMIT - 1);

    state_t        state, state_n;
    logic [WW-1:0] wcnt;
    logic          waiting;
    alu_cls_t      cls;
    logic          illegal;

    mips_mc_aludec u_aludec (
        .cls     (cls),
        .funct   (funct),
        .alu_op  (alu_op),
        .illegal (illegal)
    );

    // Next-state selection; a wait that hits the limit overrides to FAULT
    always_comb begin
        state_n = state;
        waiting = 1'b0;
        case (state)
            S_FETCH: begin
                waiting = !mem_ready;
                if (mem_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_n = S_MEMADR;
                    OP_RTYPE:         state_n = (funct == F_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI, OP_SLTI: state_n = S_ADDI_EX;
                    OP_BEQ:           state_n = S_BRANCH;
                    OP_J:             state_n = S_JUMP;
                    OP_JAL:           state_n = S_JAL;
                    default:          state_n = S_FAULT;
                endcase
            end
            S_MEMADR:  state_n = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                waiting = !mem_ready;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWR: begin
                waiting = !mem_ready;
                if (mem_ready) state_n = S_FETCH;
            end
            S_EXEC_R:  state_n = illegal ? S_FAULT : S_ALUWB;
            S_ADDI_EX: state_n = S_IMMWB;
            S_ALUWB, S_MEMWB, S_IMMWB, S_BRANCH,
            S_JUMP, S_JAL, S_JR: state_n = S_FETCH;
            default:   state_n = S_FAULT;
        endcase
        if (waiting && wcnt == WLAST) state_n = S_FAULT;
    end

    // State register and consecutive wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= (waiting && state_n == state) ? wcnt + 1'b1 : '0;
        end
    end

    // Moore decode; FETCH strobes follow mem_ready, BRANCH follows zero
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        reg_dst    = RD_RT;
        mem_to_reg = MTR_ALUOUT;
        pc_src     = PC_ALU;
        fault      = 1'b0;
        cls        = CLS_ADD;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready & rst;
                pc_write  = mem_ready & rst;
            end
            S_DECODE:  alu_src_b = SRCB_IMM4;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_MDR;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                cls       = CLS_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                cls       = (opcode == OP_SLTI) ? CLS_SLT : CLS_ADD;
            end
            S_IMMWB:   reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = PC_ALUOUT;
                pc_write  = zero;
                cls       = CLS_SUB;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = PC_RS;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = PC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = RD_R31;
                mem_to_reg = MTR_PC;
            end
            default:   fault = 1'b1;
        endcase
    end

`ifdef MIPS_MC_PERF_EN
    // Retired-instruction and wait-cycle counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (state != S_FETCH && state_n == S_FETCH)
                instr_count <= instr_count + 32'd1;
            if (waiting)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller.
// Perf counter checks compile only with MIPS_MC_PERF_EN.
module tb_mips_mc_controller;

    localparam int WL = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_write, alu_src_a, fault;
    logic [1:0] alu_src_b, reg_dst, mem_to_reg, pc_src;
    logic [2:0] alu_op;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] instr_count, stall_count;
`endif

    mips_mc_controller #(.WAIT_LIMIT(WL)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .fault      (fault)
`ifdef MIPS_MC_PERF_EN
        ,
        .instr_count(instr_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_EXEC_R, T_ALUWB, T_ADDI_EX, T_IMMWB, T_BRANCH,
        T_JUMP, T_JAL, T_JR, T_FAULT
    } tst_t;

    typedef struct {
        logic [18:0] vec;
        logic        mr;
        logic        chk;
        string       name;
    } item_t;

    item_t      sbq[$];
    int         errors = 0;
    int         checks = 0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_fn = '0;
    logic       cur_zero = 1'b0;
    logic [18:0] obs;

    assign obs = {pc_write, iord, mem_read, mem_write, ir_write,
                  reg_write, alu_src_a, fault, alu_src_b, reg_dst,
                  mem_to_reg, pc_src, alu_op};

    // Expected outputs per state, taken from the control tables
    function automatic logic [18:0] model(tst_t s, logic mr);
        logic pw, io, rd, wr, irw, rw, sa, fl;
        logic [1:0] sb, dst, mt, ps;
        logic [2:0] op;
        pw = 0; io = 0; rd = 0; wr = 0; irw = 0; rw = 0; sa = 0; fl = 0;
        sb = 2'b00; dst = 2'b00; mt = 2'b00; ps = 2'b00; op = 3'b000;
        case (s)
            T_FETCH:   begin rd = 1; sb = 2'b01; irw = mr; pw = mr; end
            T_DECODE:  sb = 2'b11;
            T_MEMADR:  begin sa = 1; sb = 2'b10; end
            T_MEMRD:   begin io = 1; rd = 1; end
            T_MEMWR:   begin io = 1; wr = 1; end
            T_MEMWB:   begin rw = 1; mt = 2'b01; end
            T_EXEC_R: begin
                sa = 1;
                case (cur_fn)
                    6'b100010: op = 3'b001;
                    6'b100100: op = 3'b010;
                    6'b100101: op = 3'b011;
                    6'b101010: op = 3'b100;
                    default:   op = 3'b000;
                endcase
            end
            T_ALUWB:   begin rw = 1; dst = 2'b01; end
            T_ADDI_EX: begin
                sa = 1; sb = 2'b10;
                op = (cur_op == 6'b001010) ? 3'b100 : 3'b000;
            end
            T_IMMWB:   rw = 1;
            T_BRANCH:  begin sa = 1; ps = 2'b01; op = 3'b001; pw = cur_zero; end
            T_JUMP:    begin pw = 1; ps = 2'b10; end
            T_JR:      begin pw = 1; ps = 2'b11; end
            T_JAL:     begin pw = 1; ps = 2'b10; rw = 1; dst = 2'b10; mt = 2'b10; end
            default:   fl = 1;
        endcase
        return {pw, io, rd, wr, irw, rw, sa, fl, sb, dst, mt, ps, op};
    endfunction

    task automatic push(input tst_t s, input logic mr, input logic chk = 1'b1);
        item_t it;
        it.vec  = model(s, mr);
        it.mr   = mr;
        it.chk  = chk;
        it.name = s.name();
        sbq.push_back(it);
    endtask

    // One queue entry per cycle: drive inputs, sample, then advance
    task automatic drain();
        item_t it;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            mem_ready = it.mr;
            zero      = cur_zero;
            #1;
            if (it.chk) begin
                checks++;
                if (obs !== it.vec) begin
                    errors++;
                    $display("FAIL %s: observed %b expected %b", it.name, obs, it.vec);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_fetch(input string tag);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== model(T_FETCH, 1'b0)) begin
            errors++;
            $display("FAIL latency_%s: observed %b expected %b", tag, obs, model(T_FETCH, 1'b0));
        end
    endtask

    task automatic reset_dut(input logic chk);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        if (chk) begin
            checks++;
            if (obs !== model(T_FETCH, 1'b0)) begin
                errors++;
                $display("FAIL reset_fetch: observed %b expected %b", obs, model(T_FETCH, 1'b0));
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic queue_instr(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int stalls);
        cur_op = op; cur_fn = fn; cur_zero = z;
        opcode = op; funct = fn;
        push(T_FETCH, 1'b1);
        push(T_DECODE, 1'b1);
        case (op)
            6'b100011: begin
                push(T_MEMADR, 1'b1);
                for (int i = 0; i < stalls; i++) push(T_MEMRD, 1'b0);
                push(T_MEMRD, 1'b1);
                push(T_MEMWB, 1'b1);
            end
            6'b101011: begin
                push(T_MEMADR, 1'b1);
                for (int i = 0; i < stalls; i++) push(T_MEMWR, 1'b0);
                push(T_MEMWR, 1'b1);
            end
            6'b000000: begin
                if (fn == 6'b001000) push(T_JR, 1'b1);
                else begin push(T_EXEC_R, 1'b1); push(T_ALUWB, 1'b1); end
            end
            6'b001000, 6'b001010: begin push(T_ADDI_EX, 1'b1); push(T_IMMWB, 1'b1); end
            6'b000100: push(T_BRANCH, 1'b1);
            6'b000010: push(T_JUMP, 1'b1);
            default:   push(T_JAL, 1'b1);
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int stalls, input string tag);
        queue_instr(op, fn, z, stalls);
        drain();
        check_fetch(tag);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== model(T_FETCH, 1'b0)) begin
            errors++;
            $display("FAIL reset_async: observed %b expected %b", obs, model(T_FETCH, 1'b0));
        end
        @(negedge clk);
        checks++;
        if (obs !== model(T_FETCH, 1'b0)) begin
            errors++;
            $display("FAIL reset_hold: observed %b expected %b", obs, model(T_FETCH, 1'b0));
        end
`ifdef MIPS_MC_PERF_EN
        checks++;
        if (instr_count !== 32'd0 || stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: observed %0d/%0d expected 0/0", instr_count, stall_count);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_rtype();
        logic [5:0] fns [5];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        foreach (fns[i]) run_instr(6'b000000, fns[i], 1'b0, 0, "rtype");
    endtask

    task automatic test_mem();
        run_instr(6'b100011, 6'b0, 1'b0, 3, "lw_stall");
        run_instr(6'b100011, 6'b0, 1'b0, 0, "lw");
        run_instr(6'b101011, 6'b0, 1'b0, 0, "sw");
        run_instr(6'b101011, 6'b0, 1'b0, 2, "sw_stall");
    endtask

    task automatic test_imm_jump();
        run_instr(6'b001000, 6'b0, 1'b0, 0, "addi");
        run_instr(6'b001010, 6'b0, 1'b0, 0, "slti");
        run_instr(6'b000010, 6'b0, 1'b0, 0, "j");
        run_instr(6'b000011, 6'b0, 1'b0, 0, "jal");
        run_instr(6'b000000, 6'b001000, 1'b0, 0, "jr");
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 6'b0, 1'b1, 0, "beq_taken");
        run_instr(6'b000100, 6'b0, 1'b0, 0, "beq_not_taken");
    endtask

    task automatic test_ready_at_limit();
        reset_dut(1'b0);
        for (int i = 0; i < WL - 1; i++) push(T_FETCH, 1'b0);
        run_instr(6'b000010, 6'b0, 1'b0, 0, "ready_at_limit");
    endtask

    task automatic test_wait_limit();
        reset_dut(1'b0);
        for (int i = 0; i < WL; i++) push(T_FETCH, 1'b0);
        for (int i = 0; i < 4; i++) push(T_FAULT, i[0]);
        drain();
        reset_dut(1'b1);
        run_instr(6'b000010, 6'b0, 1'b0, 0, "after_fault");
    endtask

    task automatic test_illegal();
        reset_dut(1'b0);
        cur_op = 6'b111111; opcode = 6'b111111;
        push(T_FETCH, 1'b1);
        push(T_DECODE, 1'b1);
        push(T_FAULT, 1'b1);
        push(T_FAULT, 1'b1);
        drain();
        reset_dut(1'b0);
        cur_op = 6'b000000; opcode = 6'b000000;
        cur_fn = 6'b000111; funct = 6'b000111;
        push(T_FETCH, 1'b1);
        push(T_DECODE, 1'b1);
        push(T_EXEC_R, 1'b1, 1'b0);
        push(T_FAULT, 1'b1);
        push(T_FAULT, 1'b0);
        drain();
        reset_dut(1'b0);
    endtask

    task automatic test_mid_reset();
        cur_op = 6'b101011; opcode = 6'b101011;
        push(T_FETCH, 1'b1);
        push(T_DECODE, 1'b1);
        push(T_MEMADR, 1'b1);
        push(T_MEMWR, 1'b0);
        drain();
        mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || obs !== model(T_FETCH, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset: observed %b expected %b", obs, model(T_FETCH, 1'b0));
        end
        @(negedge clk);
        rst = 1'b1;
        run_instr(6'b000000, 6'b100000, 1'b0, 0, "after_mid_reset");
    endtask

`ifdef MIPS_MC_PERF_EN
    task automatic test_perf();
        reset_dut(1'b0);
        push(T_FETCH, 1'b0);
        push(T_FETCH, 1'b0);
        for (int i = 0; i < 10; i++) queue_instr(6'b000000, 6'b100000, 1'b0, 0);
        drain();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instr_count !== 32'd10) begin
            errors++;
            $display("FAIL instr_count: observed %0d expected 10", instr_count);
        end
        checks++;
        if (stall_count !== 32'd2) begin
            errors++;
            $display("FAIL stall_count: observed %0d expected 2", stall_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_imm_jump();
        test_branch();
        test_ready_at_limit();
        test_wait_limit();
        test_illegal();
        test_mid_reset();
`ifdef MIPS_MC_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum consecutive memory wait cycles before a fault.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have inputs opcode[5:0] and funct[5:0] (instruction register fields), zero (1, ALU zero flag) and mem_ready (1, memory completes the access this cycle).
REQ-005 SHALL have 1-bit outputs pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a and fault.
REQ-006 SHALL have outputs alu_src_b[1:0], reg_dst[1:0], mem_to_reg[1:0], pc_src[1:0] and alu_op[2:0].

Function
REQ-007 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, ADDI_EX, IMMWB, BRANCH, JUMP, JAL, JR and FAULT; outputs depend on state only, except pc_write in BRANCH.
REQ-008 Encodings SHALL be:
- alu_op: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- alu_src_b: 00 B, 01 const 4, 10 sext imm, 11 sext imm<<2.
- pc_src: 00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- reg_dst: 00 rt, 01 rd, 10 r31.
- mem_to_reg: 00 ALUOut, 01 MDR, 10 PC.
REQ-009 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01 and alu_op=add.
- If mem_ready=1: also assert ir_write=1 and pc_write=1 (pc_src=00), then go to DECODE.
- Otherwise hold in FETCH.
REQ-010 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=add (branch target), then dispatch:
- 100011/101011 -> MEMADR
- 000000 -> EXEC_R, or JR when funct=001000
- 001000/001010 -> ADDI_EX
- 000100 -> BRANCH
- 000010 -> JUMP
- 000011 -> JAL
- any other opcode -> FAULT
REQ-011 EXEC_R SHALL decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, with alu_src_a=1 and alu_src_b=00; any other funct -> FAULT.
REQ-012 ALUWB SHALL assert reg_write=1 with reg_dst=01 and mem_to_reg=00, then go to FETCH.
REQ-013 MEMADR SHALL compute A+sext imm (alu_src_a=1, alu_src_b=10, alu_op=add), then go to MEMRD for lw or MEMWR for sw.
REQ-014 MEMRD and MEMWR SHALL drive iord=1 and hold mem_read, respectively mem_write, until mem_ready=1.
- MEMRD then goes to MEMWB.
- MEMWR then goes to FETCH.
REQ-015 MEMWB SHALL assert reg_write=1 with reg_dst=00 and mem_to_reg=01, then go to FETCH.
REQ-016 ADDI_EX SHALL use alu_src_a=1 and alu_src_b=10, with alu_op=add for addi or slt for slti; IMMWB then writes with reg_dst=00 and mem_to_reg=00.
REQ-017 BRANCH SHALL use alu_op=sub, alu_src_a=1, alu_src_b=00 and pc_src=01, with pc_write=zero.
REQ-018 JUMP and JR SHALL assert pc_write=1 with pc_src 10 and 11 respectively.
REQ-019 JAL SHALL assert pc_write=1 with pc_src=10, plus reg_write=1 with reg_dst=10 and mem_to_reg=10.
REQ-020 BRANCH, JUMP, JR and JAL SHALL each return to FETCH.
REQ-021 Latency with mem_ready held 1 SHALL be:
- R-type, sw, addi and slti: 4 cycles.
- lw: 5 cycles.
- beq, j, jal and jr: 3 cycles.
REQ-022 A wait counter SHALL count consecutive cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0; it clears on any state change or on mem_ready=1.
REQ-023 When the wait counter reaches WAIT_LIMIT, the next state SHALL be FAULT.
REQ-024 FAULT SHALL be absorbing until reset, assert fault=1 and hold every other output at 0.
REQ-025 If mem_ready rises in the same cycle the wait counter reaches WAIT_LIMIT, the access SHALL complete and no fault SHALL occur.

Reset
REQ-026 With rst=0, the FSM SHALL enter FETCH immediately, clear the wait counter and drive every output to 0 except the FETCH Moore outputs.
REQ-027 Reset mid-access SHALL abandon the access with no write strobe asserted after rst falls.

Configuration
REQ-028 With macro MIPS_MC_PERF_EN defined, the block SHALL add outputs instr_count[31:0] and stall_count[31:0].
- instr_count increments on each return to FETCH from a terminal state.
- stall_count increments on each wait cycle.
- Both reset to 0 and wrap at 2^32.
REQ-029 Without MIPS_MC_PERF_EN, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package mips_mc_pkg SHALL hold:
- the state enum;
- the opcode and funct localparams;
- the alu_op, alu_src_b, pc_src, reg_dst and mem_to_reg encodings.
REQ-031 Sub-module mips_mc_aludec SHALL map state-class and funct to alu_op and an illegal flag.

Verification
REQ-032 The bench SHALL cover all of the following:
- opcode 000000, funct 100000, mem_ready=1: states FETCH, DECODE, EXEC_R, ALUWB, FETCH; reg_write=1 in cycle 4 with reg_dst=01.
- lw with mem_ready=0 for 3 cycles in MEMRD: lw completes in 8 cycles; mem_read stays high through the stall; no fault.
- beq with zero=1, then beq with zero=0: pc_write=1 in BRANCH for the first, 0 for the second; both take 3 cycles.
- WAIT_LIMIT=15 with mem_ready stuck at 0 in FETCH: fault=1 after 15 wait cycles and remains set; rst low then high returns the FSM to FETCH with fault=0.
- opcode 111111: DECODE goes to FAULT; funct 000111 in EXEC_R goes to FAULT.
- PERF build, 10 R-type instructions plus 2 wait cycles: instr_count=10, stall_count=2.
